// File: rtl/multdiv_unit_if.sv
// Handshake/data bundle between the X-stage control and the multiply/divide unit.
// master: pipeline side (drives start pulses and operands, observes result/status).
// slave : multdiv_unit (observes start pulses and operands, drives result/status).
interface multdiv_unit_if #(
   parameter int unsigned WIDTH = 32
);
   logic             ctrl_mult;
   logic             ctrl_div;
   logic [WIDTH-1:0] data_operandA;
   logic [WIDTH-1:0] data_operandB;
   logic [WIDTH-1:0] data_result;
   logic             data_exception;
   logic             multdiv_ready;
   logic             multdiv_busy;

   modport master (
      output ctrl_mult, ctrl_div, data_operandA, data_operandB,
      input  data_result, data_exception, multdiv_ready, multdiv_busy
   );

   modport slave (
      input  ctrl_mult, ctrl_div, data_operandA, data_operandB,
      output data_result, data_exception, multdiv_ready, multdiv_busy
   );
endinterface

// File: rtl/multdiv_unit.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring) unit.
// Ports:
//   clock   - system clock, rising edge
//   reset_n - asynchronous active-low reset
//   bus     - multdiv_unit_if.slave: ctrl_mult/ctrl_div start pulses, operands,
//             data_result, data_exception, multdiv_ready (1-cycle pulse), multdiv_busy
// Optional build macro: MULTDIV_EARLY_DIV0_EN - a divide by zero skips the
//   iterations and completes one edge after capture.
module multdiv_unit #(
   parameter int unsigned WIDTH = 32
) (
   input  logic          clock,
   input  logic          reset_n,
   multdiv_unit_if.slave bus
);
   localparam int unsigned CNT_W = 6;
   localparam logic [CNT_W-1:0] TERM    = CNT_W'(WIDTH);
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_MULT, S_DIV, S_DONE} state_t;

   state_t           state_q, state_n;
   logic [CNT_W-1:0] cnt_q, cnt_n;
   logic [WIDTH:0]   hi_q, hi_n;      // Booth high word (one guard bit) / division remainder
   logic [WIDTH-1:0] lo_q, lo_n;      // Booth low word / dividend shifting into quotient
   logic             qm1_q, qm1_n;
   logic [WIDTH-1:0] opa_q, opa_n, opb_q, opb_n;
   logic [WIDTH-1:0] result_q, result_n;
   logic             exc_q, exc_n, ready_q, ready_n, busy_q, busy_n;

   logic [WIDTH:0]   acc;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH-1:0] dvs;

   // State and datapath registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         qm1_q    <= 1'b0;
         opa_q    <= '0;
         opb_q    <= '0;
         result_q <= '0;
         exc_q    <= 1'b0;
         ready_q  <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_n;
         cnt_q    <= cnt_n;
         hi_q     <= hi_n;
         lo_q     <= lo_n;
         qm1_q    <= qm1_n;
         opa_q    <= opa_n;
         opb_q    <= opb_n;
         result_q <= result_n;
         exc_q    <= exc_n;
         ready_q  <= ready_n;
         busy_q   <= busy_n;
      end
   end

   // Next-state and datapath logic
   always_comb begin
      state_n  = state_q;
      cnt_n    = cnt_q;
      hi_n     = hi_q;
      lo_n     = lo_q;
      qm1_n    = qm1_q;
      opa_n    = opa_q;
      opb_n    = opb_q;
      result_n = result_q;
      exc_n    = exc_q;
      ready_n  = 1'b0;
      busy_n   = busy_q;
      acc      = hi_q;
      rem_sh   = '0;
      dvs      = opb_q[WIDTH-1] ? -opb_q : opb_q;

      case (state_q)
         S_IDLE: begin
            busy_n = 1'b0;
            if (bus.ctrl_mult || bus.ctrl_div) begin
               opa_n  = bus.data_operandA;
               opb_n  = bus.data_operandB;
               hi_n   = '0;
               qm1_n  = 1'b0;
               cnt_n  = '0;
               busy_n = 1'b1;
               if (bus.ctrl_mult) begin
                  lo_n    = bus.data_operandB;
                  state_n = S_MULT;
               end else begin
                  lo_n    = bus.data_operandA[WIDTH-1] ? -bus.data_operandA : bus.data_operandA;
                  state_n = S_DIV;
`ifdef MULTDIV_EARLY_DIV0_EN
                  // Jump straight to the fix-up step, which reports the zero divisor
                  if (bus.data_operandB == '0) cnt_n = TERM;
`endif
               end
            end
         end

         S_MULT: begin
            if (cnt_q == TERM) begin
               state_n  = S_DONE;
               ready_n  = 1'b1;
               result_n = lo_q;
               exc_n    = (hi_q[WIDTH-1:0] != {WIDTH{lo_q[WIDTH-1]}});
            end else begin
               case ({lo_q[0], qm1_q})
                  2'b01:   acc = hi_q + {opa_q[WIDTH-1], opa_q};
                  2'b10:   acc = hi_q - {opa_q[WIDTH-1], opa_q};
                  default: acc = hi_q;
               endcase
               // Arithmetic shift of {acc, lo, qm1}; guard bit keeps -2^(W-1) operands exact
               hi_n  = {acc[WIDTH], acc[WIDTH:1]};
               lo_n  = {acc[0], lo_q[WIDTH-1:1]};
               qm1_n = lo_q[0];
               cnt_n = cnt_q + CNT_W'(1);
            end
         end

         S_DIV: begin
            if (cnt_q == TERM) begin
               state_n = S_DONE;
               ready_n = 1'b1;
               if (opb_q == '0) begin
                  result_n = '0;
                  exc_n    = 1'b1;
               end else if ((opa_q == MIN_NEG) && (opb_q == '1)) begin
                  result_n = MIN_NEG;
                  exc_n    = 1'b1;
               end else begin
                  result_n = (opa_q[WIDTH-1] ^ opb_q[WIDTH-1]) ? -lo_q : lo_q;
                  exc_n    = 1'b0;
               end
            end else begin
               rem_sh = {hi_q[WIDTH-1:0], lo_q[WIDTH-1]};
               if (rem_sh >= {1'b0, dvs}) begin
                  hi_n = rem_sh - {1'b0, dvs};
                  lo_n = {lo_q[WIDTH-2:0], 1'b1};
               end else begin
                  hi_n = rem_sh;
                  lo_n = {lo_q[WIDTH-2:0], 1'b0};
               end
               cnt_n = cnt_q + CNT_W'(1);
            end
         end

         S_DONE: begin
            state_n = S_IDLE;
            busy_n  = 1'b0;
         end

         default: state_n = S_IDLE;
      endcase
   end

   assign bus.data_result    = result_q;
   assign bus.data_exception = exc_q;
   assign bus.multdiv_ready  = ready_q;
   assign bus.multdiv_busy   = busy_q;
endmodule

// File: tb/tb_multdiv_unit.sv
// Scoreboard bench for multdiv_unit: directed operations push expected
// result/exception/latency; a negedge monitor pops on every ready pulse.
module tb_multdiv_unit;
   logic clock;
   logic reset_n;

   multdiv_unit_if #(.WIDTH(32)) bus();

   multdiv_unit #(.WIDTH(32)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   typedef struct {
      logic [31:0] r;
      bit          e;
      int          l;
   } exp_t;

   exp_t        sb[$];
   int          total = 0;
   int          bad   = 0;
   int          edge_cnt = 0;
   int          cap_edge = 0;
   logic [31:0] last_res = '0;
   bit          last_exc = 1'b0;

`ifdef MULTDIV_EARLY_DIV0_EN
   localparam int DIV0_LAT = 1;
`else
   localparam int DIV0_LAT = 33;
`endif

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) edge_cnt <= edge_cnt + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
      end
   endtask

   // Monitor: compare on ready; otherwise busy must track in-flight work and result must hold
   always @(negedge clock) begin : monitor
      exp_t e;
      if (reset_n) begin
         if (bus.multdiv_ready) begin
            if (sb.size() == 0) begin
               check("unexpected_ready", 32'(bus.multdiv_ready), 32'd0);
            end else begin
               e = sb.pop_front();
               check("result", bus.data_result, e.r);
               check("exception", 32'(bus.data_exception), 32'(e.e));
               check("latency", 32'(edge_cnt - cap_edge), 32'(e.l));
               check("busy_at_ready", 32'(bus.multdiv_busy), 32'd1);
               last_res = e.r;
               last_exc = e.e;
            end
         end else if (sb.size() != 0) begin
            check("busy_inflight", 32'(bus.multdiv_busy), 32'd1);
         end else begin
            check("busy_idle", 32'(bus.multdiv_busy), 32'd0);
            check("hold_result", bus.data_result, last_res);
            check("hold_exception", 32'(bus.data_exception), 32'(last_exc));
         end
      end
   end

   // Issue one operation; optionally pulse ctrl_div at edge pulse_at, or reset at edge rst_at
   task automatic run_op(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] er, input bit ee, input int el,
                         input int pulse_at, input int rst_at);
      exp_t e;
      @(negedge clock);
      bus.ctrl_mult     = m;
      bus.ctrl_div      = d;
      bus.data_operandA = a;
      bus.data_operandB = b;
      @(posedge clock);
      #1;
      cap_edge          = edge_cnt;
      bus.ctrl_mult     = 1'b0;
      bus.ctrl_div      = 1'b0;
      bus.data_operandA = 32'hDEAD_BEEF;
      bus.data_operandB = 32'h0000_0000;
      e.r = er; e.e = ee; e.l = el;
      sb.push_back(e);
      for (int k = 1; k <= 100; k++) begin
         @(posedge clock);
         #1;
         if (k == pulse_at - 1) begin
            bus.ctrl_div      = 1'b1;
            bus.data_operandA = 32'd1000;
            bus.data_operandB = 32'd1;
         end
         if (k == pulse_at) bus.ctrl_div = 1'b0;
         if (k == rst_at) begin
            reset_n = 1'b0;
            #1;
            check("rst_result", bus.data_result, 32'd0);
            check("rst_exception", 32'(bus.data_exception), 32'd0);
            check("rst_ready", 32'(bus.multdiv_ready), 32'd0);
            check("rst_busy", 32'(bus.multdiv_busy), 32'd0);
            sb.delete();
            last_res = '0;
            last_exc = 1'b0;
            repeat (3) @(negedge clock);
            reset_n = 1'b1;
            break;
         end
         if (sb.size() == 0) break;
      end
      if (sb.size() != 0) begin
         check("ready_timeout", 32'(sb.size()), 32'd0);
         sb.delete();
      end
      repeat (3) @(negedge clock);
   endtask

   initial begin
      reset_n           = 1'b0;
      bus.ctrl_mult     = 1'b0;
      bus.ctrl_div      = 1'b0;
      bus.data_operandA = '0;
      bus.data_operandB = '0;
      #12;
      check("reset_result", bus.data_result, 32'd0);
      check("reset_exception", 32'(bus.data_exception), 32'd0);
      check("reset_ready", 32'(bus.multdiv_ready), 32'd0);
      check("reset_busy", 32'(bus.multdiv_busy), 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      repeat (2) @(negedge clock);

      //      mult  div  A             B             result        exc  lat       pulse rst
      run_op(1'b1, 1'b0, 32'd7,        -32'sd6,      32'hFFFF_FFD6, 1'b0, 33,       0,    0);
      run_op(1'b0, 1'b1, -32'sd100,    32'd7,        32'hFFFF_FFF2, 1'b0, 33,       0,    0);
      run_op(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1, 33,     0,    0);
      run_op(1'b1, 1'b0, 32'h8000_0000, 32'd1,       32'h8000_0000, 1'b0, 33,       0,    0);
      run_op(1'b0, 1'b1, 32'd5,        32'd0,        32'h0000_0000, 1'b1, DIV0_LAT, 0,    0);
      run_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 33,     0,    0);
      run_op(1'b1, 1'b1, 32'd3,        32'd4,        32'd12,        1'b0, 33,       10,   0);
      run_op(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 33,     0,    0);
      run_op(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,       1'b0, 33,       0,    0);
      run_op(1'b0, 1'b1, -32'sd7,      -32'sd2,      32'd3,         1'b0, 33,       0,    0);
      run_op(1'b0, 1'b1, 32'd7,        -32'sd2,      32'hFFFF_FFFD, 1'b0, 33,       0,    0);
      run_op(1'b0, 1'b1, 32'h8000_0000, 32'd1,       32'h8000_0000, 1'b0, 33,       0,    0);
      run_op(1'b0, 1'b1, 32'd1000,     32'd3,        32'd333,       1'b0, 33,       0,    15);
      run_op(1'b1, 1'b0, 32'd2,        32'd3,        32'd6,         1'b0, 33,       0,    0);

      repeat (4) @(negedge clock);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end
endmodule
